// File: rtl/branch_predictor_bht_if.sv
// Fetch-side lookup and resolve-side update bundle for the branch history table.
interface branch_predictor_bht_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] ir;
    logic                  update_en;
    logic [DATA_WIDTH-1:0] update_pc;
    logic                  update_taken;
    logic                  update_mispredict;
    logic                  predict_taken;
    logic [DATA_WIDTH-1:0] predict_addr;
    logic [DATA_WIDTH-1:0] mispredict_count;

    modport master (
        output pc, ir, update_en, update_pc, update_taken, update_mispredict,
        input  predict_taken, predict_addr, mispredict_count
    );

    modport slave (
        input  pc, ir, update_en, update_pc, update_taken, update_mispredict,
        output predict_taken, predict_addr, mispredict_count
    );
endinterface

// File: rtl/branch_predictor_bht.sv
// Branch history table of 2-bit saturating counters with a combinational
// next-fetch-address predictor for MIPS beq/bne/bgtz/j/jal, plus a
// saturating mispredict counter.
module branch_predictor_bht #(
    parameter int         DATA_WIDTH  = 32,
    parameter int         INDEX_WIDTH = 6,
    parameter logic [1:0] INIT_STATE  = 2'b01
) (
    input logic                   clk,
    input logic                   rst,
    branch_predictor_bht_if.slave bus
);
    localparam int DEPTH = 1 << INDEX_WIDTH;

    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BGTZ = 6'b000111;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    logic [5:0]             op;
    logic                   is_branch;
    logic                   is_jump;
    logic [DATA_WIDTH-1:0]  pcp4;
    logic [DATA_WIDTH-1:0]  br_offset;
    logic [DATA_WIDTH-1:0]  br_target;
    logic [DATA_WIDTH-1:0]  j_target;
    logic [INDEX_WIDTH-1:0] rd_idx;
    logic [INDEX_WIDTH-1:0] wr_idx;
    logic                   predict_taken;
    logic [DATA_WIDTH-1:0]  predict_addr;

    logic [1:0]             bht_q [DEPTH];
    logic [1:0]             bht_d [DEPTH];
    logic [DATA_WIDTH-1:0]  mispredict_count_q;
    logic [DATA_WIDTH-1:0]  mispredict_count_d;

    // Only the index bits of the update PC address the table.
    logic unused_update_pc;
    assign unused_update_pc = ^{bus.update_pc[DATA_WIDTH-1:INDEX_WIDTH+2],
                                bus.update_pc[1:0]};

    assign rd_idx = bus.pc[INDEX_WIDTH+1:2];
    assign wr_idx = bus.update_pc[INDEX_WIDTH+1:2];

    // Decode and target arithmetic; lookup reads the pre-update table.
    always_comb begin
        op        = bus.ir[31:26];
        is_branch = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BGTZ);
        is_jump   = (op == OP_J) || (op == OP_JAL);
        pcp4      = bus.pc + DATA_WIDTH'(4);
        br_offset = {{(DATA_WIDTH-18){bus.ir[15]}}, bus.ir[15:0], 2'b00};
        br_target = pcp4 + br_offset;
        j_target  = {pcp4[DATA_WIDTH-1:28], bus.ir[25:0], 2'b00};
        predict_taken = is_branch && bht_q[rd_idx][1];
        if (is_jump) begin
            predict_addr = j_target;
        end else if (predict_taken) begin
            predict_addr = br_target;
        end else begin
            predict_addr = pcp4;
        end
    end

    assign bus.predict_taken    = predict_taken;
    assign bus.predict_addr     = predict_addr;
    assign bus.mispredict_count = mispredict_count_q;

    // Next-state for the table and the mispredict counter; gated by update_en
    // so nothing on the update bus matters while the strobe is low.
    always_comb begin
        bht_d              = bht_q;
        mispredict_count_d = mispredict_count_q;
        if (bus.update_en) begin
            if (bus.update_taken) begin
                if (bht_q[wr_idx] != 2'b11) begin
                    bht_d[wr_idx] = bht_q[wr_idx] + 2'd1;
                end
            end else begin
                if (bht_q[wr_idx] != 2'b00) begin
                    bht_d[wr_idx] = bht_q[wr_idx] - 2'd1;
                end
            end
            if (bus.update_mispredict && (mispredict_count_q != '1)) begin
                mispredict_count_d = mispredict_count_q + DATA_WIDTH'(1);
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bht_q[i] <= INIT_STATE;
            end
            mispredict_count_q <= '0;
        end else begin
            bht_q              <= bht_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor_bht.sv
// Randomized and directed checks of the BHT predictor against an
// array-based reference model.
module tb_branch_predictor_bht;
    localparam int DW    = 32;
    localparam int IW    = 6;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predictor_bht_if #(.DATA_WIDTH(DW)) bus ();

    branch_predictor_bht #(
        .DATA_WIDTH (DW),
        .INDEX_WIDTH(IW),
        .INIT_STATE (2'b01)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    int          m_bht [DEPTH];
    longint      m_cnt;
    logic        obs_taken;
    logic [31:0] obs_addr;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
        m_cnt = 0;
    endtask

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    function automatic logic exp_taken(input logic [31:0] pc, input logic [31:0] ir);
        int op;
        op = int'(ir >> 26);
        return (op == 4 || op == 5 || op == 7) && (m_bht[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] pc, input logic [31:0] ir);
        int          op;
        int          imm;
        logic [31:0] pcp4;
        op   = int'(ir >> 26);
        pcp4 = pc + 32'd4;
        imm  = int'(ir & 32'hFFFF);
        if (imm >= 32768) imm = imm - 65536;
        if (op == 2 || op == 3)
            return (pcp4 & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) * 4);
        if (exp_taken(pc, ir))
            return pcp4 + 32'(imm * 4);
        return pcp4;
    endfunction

    // One cycle: drive, check the combinational lookup before the edge, then
    // let the model take the update that the edge applies.
    task automatic apply(input logic [31:0] pc, input logic [31:0] ir, input logic uen,
                         input logic [31:0] upc, input logic utk, input logic umis);
        bus.pc = pc;
        bus.ir = ir;
        bus.update_en = uen;
        bus.update_pc = uen ? upc : 'x;
        bus.update_taken = uen ? utk : 1'bx;
        bus.update_mispredict = umis;
        @(negedge clk);
        obs_taken = bus.predict_taken;
        obs_addr  = bus.predict_addr;
        check_val("taken", {31'd0, obs_taken}, {31'd0, exp_taken(pc, ir)});
        check_val("addr", obs_addr, exp_addr(pc, ir));
        check_val("mcount", bus.mispredict_count, m_cnt[31:0]);
        @(posedge clk);
        if (!rst && uen) begin
            if (utk) begin
                if (m_bht[idx_of(upc)] < 3) m_bht[idx_of(upc)]++;
            end else begin
                if (m_bht[idx_of(upc)] > 0) m_bht[idx_of(upc)]--;
            end
            if (umis && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        end
        #1;
    endtask

    localparam logic [31:0] PC0 = 32'h0040_0000;
    localparam logic [31:0] BEQ = 32'h1000_0003;
    localparam logic [31:0] JAL = 32'h0C10_0010;

    initial begin
        logic [5:0]  ops [6];
        logic [31:0] rpc;
        logic [31:0] rir;
        ops[0] = 6'd4; ops[1] = 6'd5; ops[2] = 6'd7;
        ops[3] = 6'd2; ops[4] = 6'd3; ops[5] = 6'd35;

        // Reset held, with an update strobe that must be discarded.
        rst = 1'b1;
        model_reset();
        bus.pc = PC0; bus.ir = BEQ;
        bus.update_en = 1'b1; bus.update_pc = PC0;
        bus.update_taken = 1'b1; bus.update_mispredict = 1'b1;
        #2;
        check_val("rst_count_async", bus.mispredict_count, 32'd0);
        check_val("rst_taken_async", {31'd0, bus.predict_taken}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_update_discard", bus.mispredict_count, 32'd0);
        check_val("rst_addr", bus.predict_addr, 32'h0040_0004);
        rst = 1'b0;

        // First edge after reset accepts the update; lookup still sees 01.
        apply(PC0, BEQ, 1'b1, PC0, 1'b1, 1'b0);
        check_val("first_lookup_taken", {31'd0, obs_taken}, 32'd0);
        check_val("first_lookup_addr", obs_addr, 32'h0040_0004);
        apply(PC0, BEQ, 1'b1, PC0, 1'b1, 1'b0);
        check_val("after_one_taken", {31'd0, obs_taken}, 32'd1);
        check_val("after_one_addr", obs_addr, 32'h0040_0010);
        apply(PC0, BEQ, 1'b0, 32'd0, 1'b0, 1'b1);
        check_val("after_two_taken", {31'd0, obs_taken}, 32'd1);

        // Saturation up, then walk down.
        repeat (3) apply(PC0, BEQ, 1'b1, PC0, 1'b1, 1'b0);
        apply(PC0, BEQ, 1'b1, PC0, 1'b0, 1'b0);
        check_val("sat_strong_taken", {31'd0, obs_taken}, 32'd1);
        apply(PC0, BEQ, 1'b1, PC0, 1'b0, 1'b0);
        check_val("weak_t_taken", {31'd0, obs_taken}, 32'd1);
        apply(PC0, BEQ, 1'b1, PC0, 1'b0, 1'b0);
        check_val("weak_nt_not_taken", {31'd0, obs_taken}, 32'd0);
        apply(PC0, BEQ, 1'b0, 32'd0, 1'b0, 1'b0);
        check_val("strong_nt_not_taken", {31'd0, obs_taken}, 32'd0);

        // Jump target independent of table.
        apply(32'h0040_0020, JAL, 1'b0, 32'd0, 1'b0, 1'b0);
        check_val("jal_addr", obs_addr, 32'h0040_0040);
        check_val("jal_taken", {31'd0, obs_taken}, 32'd0);

        // Aliasing: index 0 shared with 0x00400100, not with 0x00400004.
        repeat (2) apply(PC0, BEQ, 1'b1, PC0, 1'b1, 1'b0);
        apply(32'h0040_0100, BEQ, 1'b0, 32'd0, 1'b0, 1'b0);
        check_val("alias_same_idx", {31'd0, obs_taken}, 32'd1);
        apply(32'h0040_0004, BEQ, 1'b0, 32'd0, 1'b0, 1'b0);
        check_val("alias_other_idx", {31'd0, obs_taken}, 32'd0);

        // Simultaneous lookup/update with mispredicts, then async reset.
        repeat (5) apply(PC0, BEQ, 1'b1, PC0, 1'b0, 1'b1);
        apply(PC0, BEQ, 1'b0, 32'd0, 1'b0, 1'b0);
        check_val("mcount_five", bus.mispredict_count, 32'd5);
        repeat (2) apply(PC0, BEQ, 1'b1, PC0, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_val("mcount_async_clear", bus.mispredict_count, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(PC0, BEQ, 1'b0, 32'd0, 1'b0, 1'b0);

        // Randomized traffic over a small address window to exercise aliasing.
        for (int n = 0; n < 400; n++) begin
            rpc = PC0 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3) * 256);
            rir = {ops[$urandom_range(0, 5)], 26'($urandom)};
            if ($urandom_range(0, 3) == 0) begin
                rpc = 32'($urandom) & 32'hFFFF_FFFC;
            end
            apply(rpc, rir, 1'($urandom_range(0, 2) != 0),
                  PC0 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3) * 256),
                  1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
